// File: rtl/ppi_pkg.sv
`default_nettype none
// ============================================================================
// ppi_pkg : shared types and default sizing for the PPI bus buffer
// Rev 1.0
// ============================================================================
package ppi_pkg;

    localparam int PPI_DEFAULT_WIDTH = 8;
    localparam int PPI_DEFAULT_DEPTH = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        TURN  = 2'd1,
        DRIVE = 2'd2
    } ppi_rd_state_e;

endpackage : ppi_pkg
`default_nettype wire

// File: rtl/ppi_sync_fifo.sv
`default_nettype none
// ============================================================================
// ppi_sync_fifo : single-clock FIFO; push while full is accepted only with pop
// Rev 1.0
// ============================================================================
module ppi_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_do_pop;
    logic             w_do_push;

    assign full      = (r_count == CNT_W'(DEPTH));
    assign empty     = (r_count == '0);
    assign w_do_pop  = pop && !empty;
    assign w_do_push = push && (!full || w_do_pop);
    // Empty reads as zero so stale entries never leak onto the output
    assign dout      = empty ? '0 : r_mem[r_rd_ptr];

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule : ppi_sync_fifo
`default_nettype wire

// File: rtl/ppi_bus_buffer.sv
`default_nettype none
// ============================================================================
// ppi_bus_buffer : strobe-driven parallel bus port with write FIFO and a
// turnaround-protected read driver. Option: PPI_BUS_DROP_CNT_EN adds drop_cnt.
// Rev 1.0
// ============================================================================
module ppi_bus_buffer
    import ppi_pkg::*;
#(
    parameter int WIDTH = PPI_DEFAULT_WIDTH,
    parameter int DEPTH = PPI_DEFAULT_DEPTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cs_n,
    input  logic             rd_n,
    input  logic             wr_n,
    inout  wire logic [WIDTH-1:0] pd,
    input  logic [WIDTH-1:0] rd_data,
    output logic [WIDTH-1:0] wr_data,
    output logic             wr_valid,
    input  logic             wr_ready,
    output logic             pd_oe,
    output logic             ovf,
    input  logic             clr_ovf
`ifdef PPI_BUS_DROP_CNT_EN
    ,
    output logic [7:0]       drop_cnt
`endif
);

    ppi_rd_state_e    r_state;
    logic [WIDTH-1:0] r_hold;
    logic             r_pd_oe;
    logic             r_wr_n_prev;
    logic             r_ovf;

    logic             w_rd_cond;
    logic             w_capture;
    logic             w_full;
    logic             w_empty;
    logic             w_pop;
    logic             w_push;
    logic             w_drop;
    logic [WIDTH-1:0] w_dout;

    assign w_rd_cond = !cs_n && !rd_n && wr_n;
    // Write edges are masked while the read path owns the bus
    assign w_capture = !cs_n && rd_n && !wr_n && r_wr_n_prev && (r_state == IDLE);
    assign w_pop     = !w_empty && wr_ready;
    assign w_push    = w_capture && (!w_full || w_pop);
    assign w_drop    = w_capture && w_full && !w_pop;

    ppi_sync_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (w_push),
        .pop   (w_pop),
        .din   (pd),
        .dout  (w_dout),
        .full  (w_full),
        .empty (w_empty)
    );

    assign wr_data  = w_dout;
    assign wr_valid = !w_empty;
    assign pd_oe    = r_pd_oe;
    assign ovf      = r_ovf;
    assign pd       = r_pd_oe ? r_hold : {WIDTH{1'bz}};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_hold  <= '0;
            r_pd_oe <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_pd_oe <= 1'b0;
                    if (w_rd_cond) begin
                        r_state <= TURN;
                        r_hold  <= rd_data;
                    end
                end
                TURN: begin
                    // One dead cycle lets the host release the bus first
                    if (w_rd_cond) begin
                        r_state <= DRIVE;
                        r_pd_oe <= 1'b1;
                    end else begin
                        r_state <= IDLE;
                        r_pd_oe <= 1'b0;
                    end
                end
                DRIVE: begin
                    if (w_rd_cond) begin
                        r_pd_oe <= 1'b1;
                    end else begin
                        r_state <= IDLE;
                        r_pd_oe <= 1'b0;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_pd_oe <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_n_prev <= 1'b1;
            r_ovf       <= 1'b0;
        end else begin
            r_wr_n_prev <= wr_n;
            if (w_drop) begin
                r_ovf <= 1'b1;
            end else if (clr_ovf) begin
                r_ovf <= 1'b0;
            end
        end
    end

`ifdef PPI_BUS_DROP_CNT_EN
    logic [7:0] r_drop_cnt;

    assign drop_cnt = r_drop_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_drop_cnt <= '0;
        end else if (clr_ovf) begin
            r_drop_cnt <= w_drop ? 8'd1 : 8'd0;
        end else if (w_drop && (r_drop_cnt != 8'hFF)) begin
            r_drop_cnt <= r_drop_cnt + 8'd1;
        end
    end
`endif

endmodule : ppi_bus_buffer
`default_nettype wire
